// File: rtl/io_interface.sv
// Programmed-I/O and interrupt logic for a basic accumulator machine.
// The block holds INPR/OUTR, the FGI/FGO flags, IEN, R and a sticky output-overrun flag.
module io_interface (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ac_in,
  input  logic       inp_cmd,
  input  logic       out_cmd,
  input  logic       ion_cmd,
  input  logic       iof_cmd,
  input  logic       fetch_phase,
  input  logic       int_ack,
  input  logic [7:0] dev_in_data,
  input  logic       dev_in_valid,
  output logic       dev_in_ready,
  output logic [7:0] dev_out_data,
  output logic       dev_out_valid,
  input  logic       dev_out_ready,
  output logic [7:0] inpr_out,
  output logic       fgi,
  output logic       fgo,
  output logic       ien,
  output logic       int_req,
  output logic       out_ovr
);

  logic [7:0] inpr_reg, inpr_next;
  logic [7:0] outr_reg, outr_next;
  logic       fgi_reg, fgi_next;
  logic       fgo_reg, fgo_next;
  logic       ien_reg, ien_next;
  logic       r_reg, r_next;
  logic       ovr_reg, ovr_next;

  logic       in_accept;
  logic       out_done;

  assign in_accept = dev_in_valid & ~fgi_reg;
  assign out_done  = dev_out_ready & ~fgo_reg;

  always_comb begin
    inpr_next = inpr_reg;
    fgi_next  = fgi_reg;
    if (in_accept) begin
      inpr_next = dev_in_data;
      fgi_next  = 1'b1;
    end else if (inp_cmd && fgi_reg) begin
      fgi_next = 1'b0;
    end
  end

  // The device handshake completes even when a rejected OUT arrives in the same
  // cycle, so a consumed character is never presented twice.
  always_comb begin
    outr_next = outr_reg;
    fgo_next  = fgo_reg;
    ovr_next  = ovr_reg;
    if (out_cmd && fgo_reg) begin
      outr_next = ac_in;
      fgo_next  = 1'b0;
    end else begin
      if (out_cmd) begin
        ovr_next = 1'b1;
      end
      if (out_done) begin
        fgo_next = 1'b1;
      end
    end
  end

  always_comb begin
    ien_next = ien_reg;
    if (int_ack || iof_cmd) begin
      ien_next = 1'b0;
    end else if (ion_cmd) begin
      ien_next = 1'b1;
    end
  end

  always_comb begin
    r_next = r_reg;
    if (int_ack) begin
      r_next = 1'b0;
    end else if (!fetch_phase && ien_reg && (fgi_reg || fgo_reg)) begin
      r_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inpr_reg <= 8'h00;
      outr_reg <= 8'h00;
      fgi_reg  <= 1'b0;
      fgo_reg  <= 1'b1;
      ien_reg  <= 1'b0;
      r_reg    <= 1'b0;
      ovr_reg  <= 1'b0;
    end else begin
      inpr_reg <= inpr_next;
      outr_reg <= outr_next;
      fgi_reg  <= fgi_next;
      fgo_reg  <= fgo_next;
      ien_reg  <= ien_next;
      r_reg    <= r_next;
      ovr_reg  <= ovr_next;
    end
  end

  assign dev_in_ready  = ~fgi_reg;
  assign dev_out_valid = ~fgo_reg;
  assign dev_out_data  = outr_reg;
  assign inpr_out      = inpr_reg;
  assign fgi           = fgi_reg;
  assign fgo           = fgo_reg;
  assign ien           = ien_reg;
  assign int_req       = r_reg;
  assign out_ovr       = ovr_reg;

endmodule
